// File: rtl/sm_als_responder.sv
// Emulated ambient-light-sensor SPI responder.
// CS and SCK are synchronized into the clk domain; the FSM loads a frame of
// {lead zeros, sample, trail zeros} on a CS fall and shifts it out MSB first.
// SDO changes on SCK falls, bits are counted on SCK rises.
module sm_als_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int LEAD_ZEROS  = 3,
   parameter int FRAME_BITS  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alsCS,
   input  logic        alsSCK,
   output logic        alsSDO,
   output logic        alsSdoOe,
   input  logic [7:0]  sample,
   output logic        busy,
   output logic        frameDone,
   output logic [15:0] frameCount
);

   localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - 8;
   localparam int CW    = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_TAIL} state_t;

   logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_cs_vld;
   logic                   r_cs_hist, r_sck_hist, r_armed;
   state_t                 r_state, w_state_nxt;
   logic [FRAME_BITS-1:0]  r_sreg, w_sreg_nxt, w_load;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic                   r_done, w_done_nxt;
   logic [15:0]            r_fcnt;
   logic                   w_cs, w_sck;
   logic                   w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;

   // Synchronizers, history registers and the re-arm qualifier.
   // r_cs_vld marks which CS stages hold real pin samples rather than reset
   // fill; r_armed only sets once a genuine high CS is seen, so a CS that is
   // still low when reset releases is never mistaken for a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_sync  <= '1;
         r_sck_sync <= '0;
         r_cs_vld   <= '0;
         r_cs_hist  <= 1'b1;
         r_sck_hist <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], alsCS};
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], alsSCK};
         r_cs_vld   <= {r_cs_vld[SYNC_STAGES-2:0], 1'b1};
         r_cs_hist  <= r_cs_sync[SYNC_STAGES-1];
         r_sck_hist <= r_sck_sync[SYNC_STAGES-1];
         r_armed    <= r_armed | (r_cs_vld[SYNC_STAGES-1] & r_cs_sync[SYNC_STAGES-1]);
      end
   end

   assign w_cs       = r_cs_sync[SYNC_STAGES-1];
   assign w_sck      = r_sck_sync[SYNC_STAGES-1];
   assign w_cs_fall  = r_armed & r_cs_hist & ~w_cs;
   assign w_cs_rise  = ~r_cs_hist & w_cs;
   assign w_sck_rise = ~r_sck_hist & w_sck;
   assign w_sck_fall = r_sck_hist & ~w_sck;
   assign w_load     = FRAME_BITS'(sample) << TRAIL;

   // Next-state, datapath next values and decoded outputs.
   // CS rise is tested first so it overrides any coincident SCK edge.
   always_comb begin
      w_state_nxt = r_state;
      w_sreg_nxt  = r_sreg;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      alsSDO      = 1'b0;
      alsSdoOe    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cs_fall) begin
               w_sreg_nxt  = w_load;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            alsSDO   = r_sreg[FRAME_BITS-1];
            alsSdoOe = 1'b1;
            busy     = 1'b1;
            if (w_cs_rise) begin
               w_state_nxt = S_IDLE;
            end else if (w_sck_rise) begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (w_cnt_nxt == CW'(FRAME_BITS)) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_TAIL;
               end
            end else if (w_sck_fall) begin
               w_sreg_nxt = {r_sreg[FRAME_BITS-2:0], 1'b0};
            end
         end
         S_TAIL: begin
            alsSdoOe = 1'b1;
            busy     = 1'b1;
            if (w_cs_rise) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, shift register, bit counter, done pulse and frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sreg  <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sreg  <= w_sreg_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         if (w_done_nxt) r_fcnt <= r_fcnt + 16'd1;
      end
   end

   assign frameDone  = r_done;
   assign frameCount = r_fcnt;

endmodule

// File: tb/tb_sm_als_responder.sv
// Directed bench for sm_als_responder: an SPI master drives CS/SCK at a
// 1:8 clk:SCK ratio and captures SDO on each SCK rise; a frame model built
// from the sample value predicts every bit, and a per-cycle monitor checks
// output invariants and the frame counter against the model.
module tb_sm_als_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alsCS = 1'b1;
   logic        alsSCK = 1'b0;
   logic [7:0]  sample = 8'h00;
   logic        alsSDO, alsSdoOe, busy, frameDone;
   logic [15:0] frameCount;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_done = 0;
   int          m_done0 = 0;
   int          bit_idx = 0;
   logic        prev_done = 1'b0;
   logic        m_settled = 1'b0;
   logic [15:0] m_fcnt = 16'h0;
   logic [7:0]  m_smp = 8'h00;
   logic [31:0] cap = 32'h0;

   sm_als_responder dut (
      .clk(clk), .rst_n(rst_n), .alsCS(alsCS), .alsSCK(alsSCK),
      .alsSDO(alsSDO), .alsSdoOe(alsSdoOe), .sample(sample),
      .busy(busy), .frameDone(frameDone), .frameCount(frameCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Frame as the master should see it: 3 zeros, sample MSB first, 5 zeros,
   // then zeros for any extra clocks.
   function automatic logic exp_bit(input logic [7:0] s, input int idx);
      logic [15:0] f;
      f = {3'b000, s, 5'b00000};
      if (idx < 16) return f[15-idx];
      return 1'b0;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // n SCK pulses, 4 clk low then 4 clk high; master samples just before rising.
   task automatic pulses(input int n, input logic active);
      for (int i = 0; i < n; i++) begin
         cyc(4);
         cap = {cap[30:0], alsSDO};
         if (active) begin
            chk("sdo_bit", 32'(alsSDO), 32'(exp_bit(m_smp, bit_idx)));
            chk("oe_in_frame", 32'(alsSdoOe), 32'd1);
         end else begin
            chk("oe_ignored", 32'(alsSdoOe), 32'd0);
            chk("busy_ignored", 32'(busy), 32'd0);
         end
         bit_idx++;
         alsSCK = 1'b1;
         cyc(4);
         alsSCK = 1'b0;
      end
   endtask

   task automatic begin_frame(input logic [7:0] s);
      sample    = s;
      m_smp     = s;
      bit_idx   = 0;
      cap       = 32'h0;
      m_settled = 1'b0;
      m_done0   = n_done;
      cyc(1);
      alsCS = 1'b0;
      cyc(8);
   endtask

   task automatic end_frame(input logic completes);
      cyc(4);
      alsCS = 1'b1;
      cyc(4);
      chk("oe_after_cs_rise", 32'(alsSdoOe), 32'd0);
      chk("busy_after_cs_rise", 32'(busy), 32'd0);
      chk("done_pulses", 32'(n_done - m_done0), 32'(completes));
      cyc(4);
      if (completes) m_fcnt = m_fcnt + 16'd1;
      m_settled = 1'b1;
   endtask

   // Per-cycle monitor.
   always @(negedge clk) begin
      if (frameDone) begin
         n_done++;
         chk("done_width", 32'(prev_done), 32'd0);
      end
      prev_done <= frameDone;
      if (!alsSdoOe) chk("sdo_zero_when_hiz", 32'(alsSDO), 32'd0);
      chk("busy_eq_oe", 32'(busy), 32'(alsSdoOe));
      if (m_settled) begin
         chk("fcnt_model", 32'(frameCount), 32'(m_fcnt));
         chk("busy_idle", 32'(busy), 32'd0);
      end
   end

   initial begin
      cyc(3);
      chk("rst_sdo", 32'(alsSDO), 32'd0);
      chk("rst_oe", 32'(alsSdoOe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frameDone), 32'd0);
      chk("rst_fcnt", 32'(frameCount), 32'd0);
      rst_n = 1'b1;
      cyc(4);
      m_settled = 1'b1;

      // Normal frame
      begin_frame(8'hA5);
      pulses(16, 1'b1);
      chk("frame_a5", cap[15:0], 32'h14A0);
      end_frame(1'b1);
      chk("fcnt_after_a5", 32'(frameCount), 32'd1);

      // Abort after 6 bits
      begin_frame(8'hFF);
      pulses(6, 1'b1);
      chk("abort_bits", cap[5:0], 32'h07);
      end_frame(1'b0);
      chk("fcnt_after_abort", 32'(frameCount), 32'd1);

      // Sample changes mid-frame
      begin_frame(8'h3C);
      pulses(4, 1'b1);
      sample = 8'hC3;
      pulses(12, 1'b1);
      chk("frame_3c", cap[15:0], 32'h0780);
      end_frame(1'b1);
      begin_frame(8'hC3);
      pulses(16, 1'b1);
      chk("frame_c3", cap[15:0], 32'h1860);
      end_frame(1'b1);
      chk("fcnt_after_c3", 32'(frameCount), 32'd3);

      // Extra clocks beyond the frame
      begin_frame(8'h81);
      pulses(20, 1'b1);
      chk("frame_81_x20", cap[19:0], 32'h10200);
      end_frame(1'b1);
      chk("fcnt_after_extra", 32'(frameCount), 32'd4);

      // Reset mid-frame with CS held low
      begin_frame(8'h5A);
      pulses(8, 1'b1);
      rst_n = 1'b0;
      cyc(1);
      chk("midrst_sdo", 32'(alsSDO), 32'd0);
      chk("midrst_oe", 32'(alsSdoOe), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_fcnt", 32'(frameCount), 32'd0);
      rst_n = 1'b1;
      m_fcnt = 16'h0;
      cyc(1);
      m_settled = 1'b1;
      pulses(4, 1'b0);
      alsCS = 1'b1;
      cyc(8);
      begin_frame(8'h5A);
      pulses(16, 1'b1);
      chk("frame_5a", cap[15:0], 32'h0B40);
      end_frame(1'b1);
      chk("fcnt_after_rst", 32'(frameCount), 32'd1);

      // Counter wrap
      m_settled = 1'b0;
      force dut.r_fcnt = 16'hFFFF;
      cyc(1);
      release dut.r_fcnt;
      cyc(1);
      m_fcnt = 16'hFFFF;
      chk("fcnt_preload", 32'(frameCount), 32'hFFFF);
      begin_frame(8'hA5);
      pulses(16, 1'b1);
      chk("frame_wrap", cap[15:0], 32'h14A0);
      end_frame(1'b1);
      chk("fcnt_wrapped", 32'(frameCount), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
